// File: rtl/uart_pkg.sv
// Shared UART definitions for the RX and TX sides: FSM state encoding and line levels.
// Pure declarations, no logic; the serial line idles high and a frame begins with a low start bit.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_state_t;

  localparam logic UART_IDLE_LVL  = 1'b1;
  localparam logic UART_START_LVL = 1'b0;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, with a selectable reset value.
// Latency 2 cycles; no handshake, the output simply follows the input.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: centre-samples start, m data bits (LSB first) and stop; word + DV pulse on a good stop.
// Latency 2+(CLKS_PER_BIT-1)/2+(m+1)*CLKS_PER_BIT+1 cycles from start edge; no backpressure, o_Rx_b holds.
module uart_rx
  import uart_pkg::*;
#(
  parameter int m            = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_Rx_serial,
  output logic [m-1:0] o_Rx_b,
  output logic         o_Rx_DV,
  output logic         o_Rx_active,
  output logic         o_frame_err
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (m > 1) ? $clog2(m) : 1;

  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(m - 1);

  uart_state_t       state;
  uart_state_t       state_nxt;
  logic              rx_s;
  logic [CNT_W-1:0]  clk_cnt;
  logic [IDX_W-1:0]  bit_idx;
  logic [m-1:0]      shreg;
  logic              mid_tick;
  logic              bit_tick;

  sync_2ff #(
    .RST_VAL(UART_IDLE_LVL)
  ) u_sync (
    .clk  (i_clk),
    .rst_n(i_rst_n),
    .d    (i_Rx_serial),
    .q    (rx_s)
  );

  assign mid_tick = (clk_cnt == CNT_MID);
  assign bit_tick = (clk_cnt == CNT_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (rx_s == UART_START_LVL) state_nxt = START;
      end
      START: begin
        if (mid_tick) state_nxt = (rx_s == UART_START_LVL) ? DATA : IDLE;
      end
      DATA: begin
        if (bit_tick && (bit_idx == IDX_LAST)) state_nxt = STOP;
      end
      // Leaving STOP at mid-bit lets a back-to-back start edge be caught in IDLE.
      STOP: begin
        if (bit_tick) state_nxt = (rx_s == UART_IDLE_LVL) ? IDLE : BREAK;
      end
      BREAK: begin
        if (rx_s == UART_IDLE_LVL) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_Rx_active = 1'b0;
    case (state)
      START, DATA, STOP: o_Rx_active = 1'b1;
      default:           o_Rx_active = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      clk_cnt     <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      o_Rx_b      <= '0;
      o_Rx_DV     <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_Rx_DV     <= 1'b0;
      o_frame_err <= 1'b0;
      case (state)
        START: begin
          if (mid_tick) begin
            clk_cnt <= '0;
            bit_idx <= '0;
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_tick) begin
            shreg[bit_idx] <= rx_s;
            clk_cnt        <= '0;
            if (bit_idx != IDX_LAST) bit_idx <= bit_idx + IDX_W'(1);
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (bit_tick) begin
            clk_cnt <= '0;
            if (rx_s == UART_IDLE_LVL) begin
              o_Rx_b  <= shreg;
              o_Rx_DV <= 1'b1;
            end else begin
              o_frame_err <= 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        default: clk_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of single frames plus hand-written glitch, back-to-back,
// mid-frame reset and loopback-stream sequences, all driven by a bit-period serial model.
module tb_uart_rx;

  localparam int M   = 8;
  localparam int CPB = 4;
  localparam int LAT = 2 + (CPB - 1) / 2 + (M + 1) * CPB + 1;
  localparam int NV  = 5;

  typedef struct {
    logic [7:0] data;
    logic       stop_ok;
    int         exp_dv;
    int         exp_err;
    logic [7:0] exp_b;
  } vec_t;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic         rx    = 1'b1;
  logic [M-1:0] rx_b;
  logic         dv;
  logic         active;
  logic         ferr;

  uart_rx #(
    .m           (M),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_Rx_serial(rx),
    .o_Rx_b     (rx_b),
    .o_Rx_DV    (dv),
    .o_Rx_active(active),
    .o_frame_err(ferr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] dv_data[$];
  int         dv_cyc[$];
  int         err_cnt  = 0;
  int         both_cnt = 0;

  always @(negedge clk) begin
    if (dv) begin
      dv_data.push_back(rx_b);
      dv_cyc.push_back(cyc);
    end
    if (ferr) err_cnt++;
    if (dv && ferr) both_cnt++;
  end

  int         n_checks = 0;
  int         n_pass   = 0;
  int         frame_start;
  int         act_n;
  vec_t       tbl[NV];
  logic [7:0] lb_words[3];
  logic [7:0] a5;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic clear_mon();
    dv_data.delete();
    dv_cyc.delete();
    err_cnt = 0;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  // Called just after a falling clock edge; the next rising edge is the first to see the start bit.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    frame_start = cyc + 1;
    send_bit(1'b0);
    for (int i = 0; i < M; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  initial begin
    tbl[0] = '{8'hEB, 1'b1, 1, 0, 8'hEB};
    tbl[1] = '{8'h5A, 1'b1, 1, 0, 8'h5A};
    tbl[2] = '{8'hFF, 1'b0, 0, 1, 8'h5A};
    tbl[3] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
    tbl[4] = '{8'h00, 1'b0, 0, 1, 8'hA5};
    lb_words[0] = 8'hEB;
    lb_words[1] = 8'h01;
    lb_words[2] = 8'h80;

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rx_b", rx_b, 0);
    check("reset_dv", dv, 0);
    check("reset_active", active, 0);
    check("reset_frame_err", ferr, 0);
    rst_n = 1'b1;
    idle(5);

    for (int v = 0; v < NV; v++) begin
      clear_mon();
      send_frame(tbl[v].data, tbl[v].stop_ok);
      if (!tbl[v].stop_ok) begin
        rx = 1'b0;
        repeat (6) @(negedge clk);
        check($sformatf("v%0d_active_in_break", v), active, 0);
        repeat (4) @(negedge clk);
      end
      idle(12);
      check($sformatf("v%0d_dv_count", v), dv_data.size(), tbl[v].exp_dv);
      check($sformatf("v%0d_err_count", v), err_cnt, tbl[v].exp_err);
      check($sformatf("v%0d_rx_b", v), rx_b, tbl[v].exp_b);
      if (tbl[v].exp_dv == 1 && dv_data.size() > 0) begin
        check($sformatf("v%0d_dv_data", v), dv_data[0], tbl[v].exp_b);
        check($sformatf("v%0d_latency", v), dv_cyc[0] - frame_start, LAT);
      end
    end

    // Single-cycle low glitch on an idle line
    clear_mon();
    act_n = 0;
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (active) act_n++;
    end
    check("glitch_dv_count", dv_data.size(), 0);
    check("glitch_err_count", err_cnt, 0);
    check("glitch_active_idle_after", active, 0);
    n_checks++;
    if (act_n >= 1 && act_n <= 2) n_pass++;
    else $display("FAIL glitch_active_cycles: got %0d, expected 1..2", act_n);

    // Back-to-back frames with no idle gap
    clear_mon();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(12);
    check("b2b_dv_count", dv_data.size(), 2);
    if (dv_data.size() == 2) begin
      check("b2b_word0", dv_data[0], 8'h00);
      check("b2b_word1", dv_data[1], 8'hFF);
      check("b2b_spacing", dv_cyc[1] - dv_cyc[0], (M + 2) * CPB);
    end

    // Reset pulled during data bit 3 of 8'hA5
    clear_mon();
    a5 = 8'hA5;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(a5[i]);
    rx = a5[3];
    repeat (2) @(negedge clk);
    check("pre_reset_active", active, 1);
    rst_n = 1'b0;
    #1;
    check("midreset_rx_b", rx_b, 0);
    check("midreset_active", active, 0);
    check("midreset_dv", dv, 0);
    check("midreset_frame_err", ferr, 0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(50);
    check("midreset_no_dv", dv_data.size(), 0);
    check("midreset_no_err", err_cnt, 0);
    clear_mon();
    send_frame(8'h3C, 1'b1);
    idle(12);
    check("after_reset_dv_count", dv_data.size(), 1);
    if (dv_data.size() == 1) begin
      check("after_reset_word", dv_data[0], 8'h3C);
      check("after_reset_latency", dv_cyc[0] - frame_start, LAT);
    end

    // Transmitter-style word stream
    clear_mon();
    send_frame(lb_words[0], 1'b1);
    send_frame(lb_words[1], 1'b1);
    idle(2);
    send_frame(lb_words[2], 1'b1);
    idle(12);
    check("stream_dv_count", dv_data.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < dv_data.size()) check($sformatf("stream_word%0d", i), dv_data[i], lb_words[i]);
    end

    check("dv_and_err_same_cycle", both_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
